// File: rtl/ga_issue_queue.sv
// ---------------------------------------------------------------------------
// ga_issue_queue
//
// Front end for ga_coprocessor. Custom-0 GA instructions arrive from the host
// core and are buffered in a small FIFO. The head entry is decoded into a
// ga_req_t and issued to the coprocessor, with only one request in flight at
// a time. The tagged 32-bit result and its status are then returned to the
// core. If the coprocessor never answers, the instruction completes with a
// timeout error.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   in_valid_i/ready_o    instruction channel from the core
//   in_instr_i, in_id_i   raw 32-bit instruction and its core tag
//   resp_valid_o/ready_i  result channel back to the core
//   resp_id_o             tag of the completed instruction
//   resp_data_o           ga result bits [31:0]
//   resp_error_o          any error (coprocessor error, illegal or timeout)
//   resp_illegal_o        head opcode was not custom-0
//   resp_timeout_o        coprocessor did not answer in time
//   resp_ovf_o            coprocessor reported overflow or underflow
//   ga_req_o / ga_resp_i  request to / response from ga_coprocessor
//   count_o               FIFO occupancy
//   stall_cycles_o        saturating count of cycles the core was back-pressured
// ---------------------------------------------------------------------------

package ga_pkg;

    typedef enum logic [3:0] {
        GA_GP    = 4'd0,
        GA_ADD   = 4'd1,
        GA_SUB   = 4'd2,
        GA_WEDGE = 4'd3,
        GA_DOT   = 4'd4,
        GA_REV   = 4'd5,
        GA_DUAL  = 4'd6,
        GA_NORM  = 4'd7
    } ga_funct_e;

    typedef struct packed {
        logic        valid;
        ga_funct_e   funct;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [4:0]  ga_reg_a;
        logic [4:0]  ga_reg_b;
        logic [4:0]  rd_addr;
        logic        we;
        logic        use_ga_regs;
    } ga_req_t;

    typedef struct packed {
        logic        ready;
        logic        busy;
        logic        valid;
        logic [63:0] result;
        logic        error;
        logic        overflow;
        logic        underflow;
    } ga_resp_t;

endpackage

module ga_issue_queue
    import ga_pkg::*;
#(
    parameter int unsigned Depth         = 4,
    parameter int unsigned IdWidth       = 4,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              in_instr_i,
    input  logic [IdWidth-1:0]       in_id_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [IdWidth-1:0]       resp_id_o,
    output logic [31:0]              resp_data_o,
    output logic                     resp_error_o,
    output logic                     resp_illegal_o,
    output logic                     resp_timeout_o,
    output logic                     resp_ovf_o,
    output ga_req_t                  ga_req_o,
    input  ga_resp_t                 ga_resp_i,
    output logic [$clog2(Depth):0]   count_o,
    output logic [31:0]              stall_cycles_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned TmoW = $clog2(TimeoutCycles);
    localparam logic [6:0]  OpcodeCustom0 = 7'b0001011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // FIFO storage holds data only; occupancy and pointers carry the state.
    logic [31:0]        instr_mem [Depth];
    logic [IdWidth-1:0] id_mem    [Depth];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]      count_q,  count_d;

    state_e             state_q, state_d;
    logic [TmoW-1:0]    tmo_q;
    logic [31:0]        stall_q;

    logic [IdWidth-1:0] resp_id_q;
    logic [31:0]        resp_data_q;
    logic               resp_error_q;
    logic               resp_illegal_q;
    logic               resp_timeout_q;
    logic               resp_ovf_q;

    logic               push;
    logic               pop;
    logic               fifo_nonempty;
    logic [31:0]        head_instr;
    logic [IdWidth-1:0] head_id;
    logic               head_legal;
    ga_req_t            dec_req;
    logic               can_issue;
    logic               tmo_expired;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Ready looks only at the registered count, so a full queue never accepts
    // a push even if the head pops in the same cycle.
    assign in_ready_o    = (count_q < (PtrW+1)'(Depth));
    assign push          = in_valid_i && in_ready_o;
    assign fifo_nonempty = (count_q != '0);
    assign head_instr    = instr_mem[rd_ptr_q];
    assign head_id       = id_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PtrW+1)'(1);
            2'b01:   count_d = count_q - (PtrW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= in_instr_i;
            id_mem[wr_ptr_q]    <= in_id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (in_valid_i && !in_ready_o) begin
                stall_q <= sat_inc32(stall_q);
            end
        end
    end

    // ------------------------------------------------------------------
    // Head decode
    // ------------------------------------------------------------------
    always_comb begin
        head_legal          = (head_instr[6:0] == OpcodeCustom0);
        dec_req             = '0;
        dec_req.funct       = ga_funct_e'(head_instr[25 +: $bits(ga_funct_e)]);
        dec_req.ga_reg_a    = head_instr[19:15];
        dec_req.ga_reg_b    = head_instr[24:20];
        dec_req.rd_addr     = head_instr[11:7];
        dec_req.we          = head_instr[12];
        dec_req.use_ga_regs = 1'b1;
    end

    // The coprocessor takes a request only when it is idle, ready and not
    // still presenting a previous response.
    assign can_issue   = ga_resp_i.ready && !ga_resp_i.busy && !ga_resp_i.valid;
    assign tmo_expired = (tmo_q == TmoW'(TimeoutCycles - 1));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fifo_nonempty) state_d = head_legal ? S_ISSUE : S_RESP;
            S_ISSUE: if (can_issue) state_d = S_WAIT;
            S_WAIT:  if (ga_resp_i.valid || tmo_expired) state_d = S_RESP;
            S_RESP:  if (resp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ga_req_o     = '0;
        resp_valid_o = 1'b0;
        pop          = 1'b0;
        case (state_q)
            S_ISSUE: begin
                ga_req_o       = dec_req;
                ga_req_o.valid = can_issue;
            end
            S_WAIT: begin
                ga_req_o = dec_req;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                pop          = resp_ready_i;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Timeout counter and response capture
    // ------------------------------------------------------------------
    // Captures happen only on transitions into RESP, so a late response
    // arriving in any other state cannot disturb the held result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q          <= '0;
            resp_id_q      <= '0;
            resp_data_q    <= '0;
            resp_error_q   <= 1'b0;
            resp_illegal_q <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fifo_nonempty && !head_legal) begin
                        resp_id_q      <= head_id;
                        resp_data_q    <= '0;
                        resp_error_q   <= 1'b1;
                        resp_illegal_q <= 1'b1;
                        resp_timeout_q <= 1'b0;
                        resp_ovf_q     <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (can_issue) begin
                        tmo_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (ga_resp_i.valid) begin
                        resp_id_q      <= head_id;
                        resp_data_q    <= ga_resp_i.result[31:0];
                        resp_error_q   <= ga_resp_i.error;
                        resp_illegal_q <= 1'b0;
                        resp_timeout_q <= 1'b0;
                        resp_ovf_q     <= ga_resp_i.overflow | ga_resp_i.underflow;
                    end else if (tmo_expired) begin
                        resp_id_q      <= head_id;
                        resp_data_q    <= '0;
                        resp_error_q   <= 1'b1;
                        resp_illegal_q <= 1'b0;
                        resp_timeout_q <= 1'b1;
                        resp_ovf_q     <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_id_o      = resp_id_q;
    assign resp_data_o    = resp_data_q;
    assign resp_error_o   = resp_error_q;
    assign resp_illegal_o = resp_illegal_q;
    assign resp_timeout_o = resp_timeout_q;
    assign resp_ovf_o     = resp_ovf_q;
    assign count_o        = count_q;
    assign stall_cycles_o = stall_q;

    // Upper result bits and instruction bits outside the decoded fields are
    // intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{ga_resp_i.result[63:32], head_instr[14:13],
                           head_instr[31:25+$bits(ga_funct_e)]};

endmodule
